regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and requester indices for the register-file write-back arbiter.
package regfile_pkg;

    localparam int unsigned BUS_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF     = 3;
    localparam int unsigned NUM_REQ       = 2;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_e;

endpackage : regfile_pkg

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with stall; grant is combinational, last winner is registered.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               hold_i,
    output logic [NUM_REQ-1:0] gnt_c
);

    req_idx_e last_q;
    req_idx_e last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_MEM;
        end else begin
            last_q <= last_d;
        end
    end

    // Contention goes to whoever did not win last; no grants while stalled or in reset.
    always_comb begin
        gnt_c  = '0;
        last_d = last_q;
        if (rst_n && !hold_i) begin
            case (req_i)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
                default: gnt_c = 2'b00;
            endcase
        end
        if (gnt_c[REQ_MEM]) begin
            last_d = REQ_MEM;
        end else if (gnt_c[REQ_ALU]) begin
            last_d = REQ_ALU;
        end
    end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: grants ALU/load-unit writes to one register-file port,
// registers the write, bypasses it onto both read ports, and flags bad addresses.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int unsigned BUS_WIDTH = BUS_WIDTH_DEF,
    parameter  int unsigned DEPTH     = DEPTH_DEF,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_addr,
    input  logic [BUS_WIDTH-1:0] alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [AW-1:0]        mem_addr,
    input  logic [BUS_WIDTH-1:0] mem_data,
    output logic                 mem_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wr_addr,
    output logic [BUS_WIDTH-1:0] rf_wr_data,
    input  logic [AW-1:0]        rd_addr_a,
    input  logic [AW-1:0]        rd_addr_b,
    input  logic [BUS_WIDTH-1:0] rf_rd_data_a,
    input  logic [BUS_WIDTH-1:0] rf_rd_data_b,
    output logic [BUS_WIDTH-1:0] rd_data_a,
    output logic [BUS_WIDTH-1:0] rd_data_b,
    output logic                 err_addr,
    output logic [7:0]           wr_count
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [NUM_REQ-1:0]   gnt_c;
    logic                 xfer_c;
    logic                 in_range_c;
    logic [AW-1:0]        sel_addr_c;
    logic [BUS_WIDTH-1:0] sel_data_c;

    logic                 we_q,    we_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic                 err_q,   err_d;
    logic [7:0]           cnt_q,   cnt_d;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  ({mem_valid, alu_valid}),
        .hold_i (hold),
        .gnt_c  (gnt_c)
    );

    assign alu_ready = gnt_c[REQ_ALU];
    assign mem_ready = gnt_c[REQ_MEM];

    always_comb begin
        xfer_c     = |gnt_c;
        sel_addr_c = gnt_c[REQ_MEM] ? mem_addr : alu_addr;
        sel_data_c = gnt_c[REQ_MEM] ? mem_data : alu_data;
        in_range_c = ({1'b0, sel_addr_c} < DEPTH_W);
    end

    // Out-of-range transfers are consumed but only raise the sticky error flag.
    always_comb begin
        we_d    = xfer_c && in_range_c;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q || (xfer_c && !in_range_c);
        cnt_d   = we_q ? cnt_q + 8'd1 : cnt_q;
        if (we_d) begin
            waddr_d = sel_addr_c;
            wdata_d = sel_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rf_we      = we_q;
    assign rf_wr_addr = waddr_q;
    assign rf_wr_data = wdata_q;
    assign err_addr   = err_q;
    assign wr_count   = cnt_q;

    assign rd_data_a = (we_q && (waddr_q == rd_addr_a)) ? wdata_q : rf_rd_data_a;
    assign rd_data_b = (we_q && (waddr_q == rd_addr_b)) ? wdata_q : rf_rd_data_b;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (BUS_WIDTH=8, DEPTH=3).
module tb_regfile_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic       alu_valid, mem_valid;
    logic [1:0] alu_addr, mem_addr;
    logic [7:0] alu_data, mem_data;
    logic       alu_ready, mem_ready;
    logic       rf_we;
    logic [1:0] rf_wr_addr;
    logic [7:0] rf_wr_data;
    logic [1:0] rd_addr_a, rd_addr_b;
    logic [7:0] rf_rd_data_a, rf_rd_data_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic       err_addr;
    logic [7:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.BUS_WIDTH(8), .DEPTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rf_we        (rf_we),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .err_addr     (err_addr),
        .wr_count     (wr_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one full cycle; inputs are driven and outputs sampled mid low phase.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic       exp_alu;
    logic [7:0] prev_data;

    initial begin
        rst_n = 1'b0; hold = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_addr = 2'd0; mem_addr = 2'd0; alu_data = 8'h00; mem_data = 8'h00;
        rd_addr_a = 2'd0; rd_addr_b = 2'd0; rf_rd_data_a = 8'h00; rf_rd_data_b = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state, with requests already pending
        alu_valid = 1'b1; alu_addr = 2'd1; alu_data = 8'h11;
        mem_valid = 1'b1; mem_addr = 2'd2; mem_data = 8'h22;
        #1;
        check_eq("rst_alu_ready", 32'(alu_ready), 32'd0);
        check_eq("rst_mem_ready", 32'(mem_ready), 32'd0);
        check_eq("rst_rf_we",     32'(rf_we), 32'd0);
        check_eq("rst_wr_addr",   32'(rf_wr_addr), 32'd0);
        check_eq("rst_wr_data",   32'(rf_wr_data), 32'd0);
        check_eq("rst_err",       32'(err_addr), 32'd0);
        check_eq("rst_count",     32'(wr_count), 32'd0);

        // First contention: ALU then MEM
        rst_n = 1'b1;
        #1;
        check_eq("c0_alu_ready", 32'(alu_ready), 32'd1);
        check_eq("c0_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        #1;
        check_eq("c1_rf_we",     32'(rf_we), 32'd1);
        check_eq("c1_wr_addr",   32'(rf_wr_addr), 32'd1);
        check_eq("c1_wr_data",   32'(rf_wr_data), 32'h11);
        check_eq("c1_mem_ready", 32'(mem_ready), 32'd1);
        check_eq("c1_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        mem_valid = 1'b0;
        #1;
        check_eq("c2_rf_we",     32'(rf_we), 32'd1);
        check_eq("c2_wr_addr",   32'(rf_wr_addr), 32'd2);
        check_eq("c2_wr_data",   32'(rf_wr_data), 32'h22);
        check_eq("c2_count",     32'(wr_count), 32'd1);
        tick();
        #1;
        check_eq("c3_rf_we",     32'(rf_we), 32'd0);
        check_eq("c3_count",     32'(wr_count), 32'd2);
        check_eq("c3_data_hold", 32'(rf_wr_data), 32'h22);

        // Continuous contention alternates; each winner presents fresh data next cycle
        alu_valid = 1'b1; alu_addr = 2'd0; alu_data = 8'hA0;
        mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 8'hB0;
        prev_data = 8'h00;
        for (int i = 0; i < 6; i++) begin
            exp_alu = (i % 2 == 0);
            if (i > 0) begin
                if (exp_alu) mem_data = mem_data + 8'd1;
                else         alu_data = alu_data + 8'd1;
            end
            #1;
            check_eq($sformatf("rr%0d_alu_ready", i), 32'(alu_ready), 32'(exp_alu));
            check_eq($sformatf("rr%0d_mem_ready", i), 32'(mem_ready), 32'(!exp_alu));
            check_eq($sformatf("rr%0d_onehot", i), 32'(alu_ready & mem_ready), 32'd0);
            if (i > 0) begin
                check_eq($sformatf("rr%0d_rf_we", i), 32'(rf_we), 32'd1);
                check_eq($sformatf("rr%0d_wr_data", i), 32'(rf_wr_data), 32'(prev_data));
            end
            prev_data = exp_alu ? alu_data : mem_data;
            tick();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check_eq("rr_last_rf_we",   32'(rf_we), 32'd1);
        check_eq("rr_last_wr_data", 32'(rf_wr_data), 32'hB2);
        tick();
        #1;
        check_eq("rr_count", 32'(wr_count), 32'd8);

        // Stall with both requesting, then release: ALU first
        hold = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("hold%0d_alu_ready", i), 32'(alu_ready), 32'd0);
            check_eq($sformatf("hold%0d_mem_ready", i), 32'(mem_ready), 32'd0);
            check_eq($sformatf("hold%0d_rf_we", i), 32'(rf_we), 32'd0);
            tick();
        end
        hold = 1'b0;
        #1;
        check_eq("unhold_alu_ready", 32'(alu_ready), 32'd1);
        check_eq("unhold_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check_eq("unhold_rf_we",   32'(rf_we), 32'd1);
        check_eq("unhold_wr_addr", 32'(rf_wr_addr), 32'd0);
        check_eq("unhold_wr_data", 32'(rf_wr_data), 32'hA3);
        tick();
        #1;
        check_eq("unhold_count", 32'(wr_count), 32'd9);

        // Bypass on port A, raw data on port B
        mem_valid = 1'b1; mem_addr = 2'd0; mem_data = 8'hA5;
        rd_addr_a = 2'd0; rf_rd_data_a = 8'h00;
        rd_addr_b = 2'd1; rf_rd_data_b = 8'h77;
        #1;
        check_eq("byp_mem_ready", 32'(mem_ready), 32'd1);
        check_eq("byp_pre_a",     32'(rd_data_a), 32'h00);
        tick();
        mem_valid = 1'b0;
        #1;
        check_eq("byp_rf_we", 32'(rf_we), 32'd1);
        check_eq("byp_a",     32'(rd_data_a), 32'hA5);
        check_eq("byp_b",     32'(rd_data_b), 32'h77);
        tick();
        #1;
        check_eq("byp_post_a", 32'(rd_data_a), 32'h00);
        check_eq("byp_count",  32'(wr_count), 32'd10);

        // Out-of-range address is accepted but only sets the sticky error
        alu_valid = 1'b1; alu_addr = 2'd3; alu_data = 8'h55;
        #1;
        check_eq("oor_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        check_eq("oor_rf_we", 32'(rf_we), 32'd0);
        check_eq("oor_err",   32'(err_addr), 32'd1);
        repeat (3) tick();
        #1;
        check_eq("oor_err_sticky", 32'(err_addr), 32'd1);
        check_eq("oor_count",      32'(wr_count), 32'd10);

        // Reset mid-stream discards the registered write
        alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 8'h99;
        #1;
        check_eq("mid_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        check_eq("mid_rf_we_pre", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rf_we",   32'(rf_we), 32'd0);
        check_eq("mid_count",   32'(wr_count), 32'd0);
        check_eq("mid_err",     32'(err_addr), 32'd0);
        check_eq("mid_wr_data", 32'(rf_wr_data), 32'd0);
        alu_valid = 1'b1; mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 8'h66;
        #1;
        check_eq("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
        check_eq("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("post_alu_ready", 32'(alu_ready), 32'd1);
        check_eq("post_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check_eq("post_rf_we",   32'(rf_we), 32'd1);
        check_eq("post_wr_addr", 32'(rf_wr_addr), 32'd2);
        check_eq("post_wr_data", 32'(rf_wr_data), 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
